// File: rtl/cmem_load_ctrl_pkg.sv
// Shared definitions for the compensation-memory load controller: FSM encoding,
// slots per column, and the write-address width derivation.
package cmem_load_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    localparam int CMEM_SLOTS = 3;

    function automatic int cmem_addr_width(input int entries);
        return (entries <= 1) ? 1 : $clog2(entries);
    endfunction

endpackage

// File: rtl/cmem_wr_addr_gen.sv
// Sequential write-address counter for the compensation memory; tc flags the
// last entry so the controller knows the accepted weight completes the load.
module cmem_wr_addr_gen
    import cmem_load_ctrl_pkg::*;
#(
    parameter int CMEM_SIZE       = 8 * CMEM_SLOTS,
    parameter int CMEM_ADDR_WIDTH = cmem_addr_width(CMEM_SIZE)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       inc,
    output logic [CMEM_ADDR_WIDTH-1:0] cnt,
    output logic                       tc
);

    assign tc = (cnt == CMEM_ADDR_WIDTH'(CMEM_SIZE - 1));

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= tc ? '0 : cnt + CMEM_ADDR_WIDTH'(1);
        end
    end

endmodule

// File: rtl/cmem_load_ctrl.sv
// Compensation-memory load/read controller: fills CMEM_SIZE entries from a weight
// stream, then serves slot reads. Define CMEM_LOAD_TIMEOUT_EN to abort stalled loads.
module cmem_load_ctrl
    import cmem_load_ctrl_pkg::*;
#(
    parameter int SIZE            = 8,
    parameter int CMEM_SIZE       = SIZE * CMEM_SLOTS,
    parameter int CMEM_ADDR_WIDTH = cmem_addr_width(CMEM_SIZE)
`ifdef CMEM_LOAD_TIMEOUT_EN
    ,
    parameter int TIMEOUT         = 64
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_load,
    input  logic [3:0]                 cw_in,
    input  logic                       cw_valid,
    output logic                       cw_ready,
    input  logic                       rd_req,
    input  logic [1:0]                 rd_slot,
    output logic [CMEM_ADDR_WIDTH-1:0] Wr_Addr,
    output logic [3:0]                 Wr_data,
    output logic                       Wr_en,
    output logic [1:0]                 Rd_Addr,
    output logic                       Rd_en,
    output logic                       comp_valid,
    output logic                       load_done,
    output logic                       err
);

    state_t                     state, state_nxt;
    logic [CMEM_ADDR_WIDTH-1:0] wr_cnt;
    logic                       wr_tc;
    logic                       cnt_clr;
    logic                       err_set, err_clr;
    logic                       wr_en, rd_en;
    logic                       idle_hit;
    logic                       vld_p1;

    cmem_wr_addr_gen #(
        .CMEM_SIZE       (CMEM_SIZE),
        .CMEM_ADDR_WIDTH (CMEM_ADDR_WIDTH)
    ) u_wr_addr_gen (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (wr_en),
        .cnt (wr_cnt),
        .tc  (wr_tc)
    );

`ifdef CMEM_LOAD_TIMEOUT_EN
    logic [$clog2(TIMEOUT + 1)-1:0] idle_cnt;

    always_ff @(posedge clk) begin
        if (!rst || state != LOAD || cw_valid) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // The TIMEOUT-th consecutive stalled cycle aborts the load.
    assign idle_hit = (state == LOAD) && !cw_valid &&
                      (idle_cnt == ($clog2(TIMEOUT + 1))'(TIMEOUT - 1));
`else
    assign idle_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        cw_ready  = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        cnt_clr   = 1'b0;
        err_set   = 1'b0;
        err_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (start_load) begin
                    state_nxt = LOAD;
                    cnt_clr   = 1'b1;
                    err_clr   = 1'b1;
                end else if (rd_req) begin
                    err_set = 1'b1;
                end
            end
            LOAD: begin
                cw_ready = 1'b1;
                err_set  = rd_req;
                if (cw_valid) begin
                    wr_en = 1'b1;
                    if (wr_tc) state_nxt = READY;
                end else if (idle_hit) begin
                    state_nxt = IDLE;
                    err_set   = 1'b1;
                    cnt_clr   = 1'b1;
                end
            end
            READY: begin
                // A new load takes precedence over a coincident read.
                if (start_load) begin
                    state_nxt = LOAD;
                    cnt_clr   = 1'b1;
                    err_clr   = 1'b1;
                end else if (rd_req) begin
                    if (rd_slot != 2'd3) rd_en   = 1'b1;
                    else                 err_set = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            err    <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            state  <= state_nxt;
            vld_p1 <= rd_en;
            if (err_clr)      err <= 1'b0;
            else if (err_set) err <= 1'b1;
        end
    end

    // ---- stage p1: registered RAM output valid ----
    assign comp_valid = vld_p1;
    assign load_done  = (state == READY);
    assign Wr_en      = wr_en;
    assign Wr_Addr    = wr_en ? wr_cnt : '0;
    assign Wr_data    = wr_en ? cw_in : 4'd0;
    assign Rd_en      = rd_en;
    assign Rd_Addr    = rd_en ? rd_slot : 2'd0;

endmodule

// File: tb/tb_cmem_load_ctrl.sv
// Scoreboard bench for cmem_load_ctrl: a mode/count reference model queues expected
// writes, reads and comp_valid pulses; a negedge monitor checks every cycle.
module tb_cmem_load_ctrl;

    localparam int N = 24;
`ifdef CMEM_LOAD_TIMEOUT_EN
    localparam int TO = 64;
`endif
    localparam int M_IDLE = 0, M_LOAD = 1, M_READY = 2;

    typedef struct {
        int cyc;
        int addr;
        int data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_load = 1'b0;
    logic [3:0] cw_in = 4'd0;
    logic       cw_valid = 1'b0;
    logic       rd_req = 1'b0;
    logic [1:0] rd_slot = 2'd0;
    logic       cw_ready, Wr_en, Rd_en, comp_valid, load_done, err;
    logic [4:0] Wr_Addr;
    logic [3:0] Wr_data;
    logic [1:0] Rd_Addr;

    cmem_load_ctrl #(.SIZE(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_load (start_load),
        .cw_in      (cw_in),
        .cw_valid   (cw_valid),
        .cw_ready   (cw_ready),
        .rd_req     (rd_req),
        .rd_slot    (rd_slot),
        .Wr_Addr    (Wr_Addr),
        .Wr_data    (Wr_data),
        .Wr_en      (Wr_en),
        .Rd_Addr    (Rd_Addr),
        .Rd_en      (Rd_en),
        .comp_valid (comp_valid),
        .load_done  (load_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int  vecs = 0;
    int  miscompares = 0;
    int  cyc = 0;
    bit  run = 1'b0;

    int  m_mode = M_IDLE;
    int  m_cnt = 0;
    int  m_idle = 0;
    bit  m_err = 1'b0;
    bit  exp_ready, exp_done, exp_err;
    ev_t wr_q[$];
    ev_t rd_q[$];
    int  cv_q[$];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference model: one call per cycle, using the inputs just driven.
    task automatic model_step();
        exp_ready = (m_mode == M_LOAD);
        exp_done  = (m_mode == M_READY);
        exp_err   = m_err;
        case (m_mode)
            M_IDLE: begin
                if (start_load) begin
                    m_mode = M_LOAD; m_cnt = 0; m_err = 1'b0; m_idle = 0;
                end else if (rd_req) begin
                    m_err = 1'b1;
                end
            end
            M_LOAD: begin
                if (rd_req) m_err = 1'b1;
                if (cw_valid) begin
                    wr_q.push_back('{cyc, m_cnt, int'(cw_in)});
                    m_cnt++;
                    m_idle = 0;
                    if (m_cnt == N) m_mode = M_READY;
                end else begin
                    m_idle++;
`ifdef CMEM_LOAD_TIMEOUT_EN
                    if (m_idle == TO) begin
                        m_mode = M_IDLE; m_err = 1'b1;
                    end
`endif
                end
            end
            default: begin
                if (start_load) begin
                    m_mode = M_LOAD; m_cnt = 0; m_err = 1'b0; m_idle = 0;
                end else if (rd_req) begin
                    if (rd_slot <= 2'd2) begin
                        rd_q.push_back('{cyc, int'(rd_slot), 0});
                        if (rst) cv_q.push_back(cyc + 1);
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end
        endcase
        if (!rst) begin
            m_mode = M_IDLE; m_cnt = 0; m_err = 1'b0; m_idle = 0;
        end
    endtask

    task automatic drive(int s, int v, int d, int rq, int sl, int r);
        @(posedge clk);
        #1;
        start_load = s[0];
        cw_valid   = v[0];
        cw_in      = d[3:0];
        rd_req     = rq[0];
        rd_slot    = sl[1:0];
        rst        = r[0];
        cyc++;
        model_step();
    endtask

    always @(negedge clk) begin : mon
        ev_t w, r;
        bit  ew, er, ec;
        if (run) begin
            ew = (wr_q.size() > 0) && (wr_q[0].cyc == cyc);
            if (ew) w = wr_q.pop_front();
            else    w = '{cyc, 0, 0};
            er = (rd_q.size() > 0) && (rd_q[0].cyc == cyc);
            if (er) r = rd_q.pop_front();
            else    r = '{cyc, 0, 0};
            ec = (cv_q.size() > 0) && (cv_q[0] == cyc);
            if (ec) void'(cv_q.pop_front());
            chk("wr_en",      32'(Wr_en),      32'(ew));
            chk("wr_addr",    32'(Wr_Addr),    w.addr);
            chk("wr_data",    32'(Wr_data),    w.data);
            chk("rd_en",      32'(Rd_en),      32'(er));
            chk("rd_addr",    32'(Rd_Addr),    r.addr);
            chk("comp_valid", 32'(comp_valid), 32'(ec));
            chk("cw_ready",   32'(cw_ready),   32'(exp_ready));
            chk("load_done",  32'(load_done),  32'(exp_done));
            chk("err",        32'(err),        32'(exp_err));
            chk("wr_rd_excl", 32'(Wr_en & Rd_en), 0);
        end
    end

    initial begin
        repeat (3) drive(0, 0, 0, 0, 0, 0);
        run = 1'b1;
        repeat (2) drive(0, 0, 0, 0, 0, 1);

        // Full back-to-back load, weights 1..8 repeating.
        drive(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < N; i++) drive(0, 1, (i % 8) + 1, 0, 0, 1);
        repeat (3) drive(0, 1, int'($urandom_range(0, 15)), 0, 0, 1);

        // Back-to-back slot reads, then an illegal slot and an err-clearing restart.
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, i, 1);
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 3, 1);
        drive(0, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 1);

        // Load with cw_valid alternating, plus a stray read that flags err.
        for (int i = 0; i < 2 * N; i++)
            drive(0, (i % 2 == 0) ? 1 : 0, int'($urandom_range(0, 15)), (i == 7) ? 1 : 0, 0, 1);

        for (int i = 0; i < 30; i++)
            drive(0, 0, 0, int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1);

        // Read followed by a restart that coincides with another read.
        drive(0, 0, 0, 1, 1, 1);
        drive(1, 0, 0, 1, 2, 1);

        // Reset after 10 accepted weights, then restart from address 0.
        for (int i = 0; i < 10; i++) drive(0, 1, int'($urandom_range(0, 15)), 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) drive(0, 1, int'($urandom_range(0, 15)), 0, 0, 1);

        // Long stall mid-load: aborts when the timeout is built in, waits otherwise.
        repeat (70) drive(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < N; i++) drive(0, 1, int'($urandom_range(0, 15)), 0, 0, 1);

        // Fully random traffic.
        for (int i = 0; i < 600; i++)
            drive(($urandom_range(0, 15) == 0) ? 1 : 0,
                  ($urandom_range(0, 3) != 0) ? 1 : 0,
                  int'($urandom_range(0, 15)),
                  ($urandom_range(0, 2) == 0) ? 1 : 0,
                  int'($urandom_range(0, 3)),
                  ($urandom_range(0, 63) == 0) ? 0 : 1);

        repeat (3) drive(0, 0, 0, 0, 0, 1);
        chk("drain", wr_q.size() + rd_q.size() + cv_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
